// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: walks a PWM duty value toward a commanded target in
// fixed-size steps, one step every programmed number of clock cycles.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      1 runs an in-progress ramp, 0 freezes it
//   cmd_valid  command present
//   cmd_ready  controller is idle and can accept a command
//   cmd_duty   target duty
//   cmd_step   duty increment per step (0 acts as 1)
//   cmd_rate   clock cycles per step (0 acts as 1)
//   duty_out   registered duty value to the PWM core
//   duty_load  one-cycle pulse after each duty_out change
//   busy       ramp in progress
//   done       one-cycle pulse on ramp completion
module pwm_ramp_ctrl #(
    parameter int DUTY_W = 8,
    parameter int RATE_W = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic [STEP_W-1:0] cmd_step,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [DUTY_W-1:0] duty_out,
    output logic              duty_load,
    output logic              busy,
    output logic              done
);
    localparam int EW = DUTY_W + 1;

    typedef enum logic {IDLE, RAMP} state_t;

    state_t            state;
    logic [DUTY_W-1:0] target;
    logic [STEP_W-1:0] step;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] prescaler;
    logic              dir;
    logic [EW-1:0]     up_sum;
    logic [EW-1:0]     dn_diff;
    logic [DUTY_W-1:0] nxt;

    assign cmd_ready = (state == IDLE) && !rst;

    // Step math is one bit wider than the duty so an overshoot past the top
    // or a borrow below zero is visible and clamps to the target instead of
    // wrapping.
    always_comb begin
        up_sum  = {1'b0, duty_out} + EW'(step);
        dn_diff = {1'b0, duty_out} - EW'(step);
        nxt     = dir
                ? ((up_sum > {1'b0, target}) ? target : up_sum[DUTY_W-1:0])
                : ((dn_diff[DUTY_W] || dn_diff[DUTY_W-1:0] < target) ? target : dn_diff[DUTY_W-1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            target    <= '0;
            step      <= '0;
            rate      <= '0;
            prescaler <= '0;
            dir       <= 1'b0;
            duty_out  <= '0;
            duty_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            duty_load <= 1'b0;
            done      <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid) begin
                    target <= cmd_duty;
                    step   <= (cmd_step == '0) ? STEP_W'(1) : cmd_step;
                    rate   <= (cmd_rate == '0) ? RATE_W'(1) : cmd_rate;
                    dir    <= cmd_duty > duty_out;
                    if (cmd_duty == duty_out) begin
                        done <= 1'b1;
                    end else begin
                        state     <= RAMP;
                        busy      <= 1'b1;
                        prescaler <= '0;
                    end
                end
            end else if (start) begin
                if (prescaler == rate - RATE_W'(1)) begin
                    prescaler <= '0;
                    duty_out  <= nxt;
                    duty_load <= 1'b1;
                    if (nxt == target) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end else begin
                    prescaler <= prescaler + RATE_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed and randomized checks of pwm_ramp_ctrl against a
// closed-form ramp model (duty after k steps = clamp(from +/- k*step, target)).
module tb_pwm_ramp_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_duty = '0;
    logic [3:0]  cmd_step = '0;
    logic [15:0] cmd_rate = '0;
    logic [7:0]  duty_out;
    logic        duty_load;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    int m_duty = 0, m_target = 0, m_step = 1, m_rate = 1, m_from = 0, m_cnt = 0;
    int m_busy = 0, e_load = 0, e_done = 0;
    int elapsed = 0, loads = 0;

    pwm_ramp_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty), .cmd_step(cmd_step), .cmd_rate(cmd_rate),
        .duty_out(duty_out), .duty_load(duty_load), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: counts active ramp edges since acceptance; after k whole
    // intervals the duty is the start value moved k steps, clamped at target.
    task automatic model();
        int k, v;
        e_load = 0;
        e_done = 0;
        if (rst) begin
            m_duty = 0;
            m_busy = 0;
        end else if (m_busy == 0) begin
            if (cmd_valid) begin
                m_target = int'(cmd_duty);
                m_step   = (cmd_step == 0) ? 1 : int'(cmd_step);
                m_rate   = (cmd_rate == 0) ? 1 : int'(cmd_rate);
                if (m_target == m_duty) e_done = 1;
                else begin
                    m_busy = 1;
                    m_from = m_duty;
                    m_cnt  = 0;
                end
            end
        end else if (start) begin
            m_cnt++;
            k = m_cnt / m_rate;
            if (m_target > m_from) begin
                v = m_from + k * m_step;
                if (v > m_target) v = m_target;
            end else begin
                v = m_from - k * m_step;
                if (v < m_target) v = m_target;
            end
            if (v != m_duty) e_load = 1;
            m_duty = v;
            if (v == m_target) begin
                m_busy = 0;
                e_done = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        elapsed++;
        @(negedge clk);
        loads += int'(duty_load);
        chk("duty_out", int'(duty_out), m_duty);
        chk("duty_load", int'(duty_load), e_load);
        chk("busy", int'(busy), m_busy);
        chk("done", int'(done), e_done);
        chk("cmd_ready", int'(cmd_ready), (m_busy == 0 && !rst) ? 1 : 0);
    endtask

    task automatic cmd(input int d, input int s, input int r);
        cmd_duty  = 8'(d);
        cmd_step  = 4'(s);
        cmd_rate  = 16'(r);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        elapsed   = 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000 && m_busy != 0; i++) tick();
        if (m_busy != 0) chk("idle_timeout", 1, 0);
    endtask

    task automatic wait_duty(input int d);
        for (int i = 0; i < 2000 && m_duty != d; i++) tick();
        if (m_duty != d) chk("duty_timeout", m_duty, d);
    endtask

    initial begin
        int n;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_duty", int'(duty_out), 0);

        loads = 0;
        cmd(4, 1, 3);
        wait_idle();
        chk("ramp4_cycles", elapsed, 12);
        chk("ramp4_loads", loads, 4);
        chk("ramp4_duty", int'(duty_out), 4);

        cmd(250, 15, 1);
        wait_idle();
        loads = 0;
        cmd(255, 15, 1);
        wait_idle();
        chk("sat_loads", loads, 1);
        chk("sat_duty", int'(duty_out), 255);
        loads = 0;
        cmd(0, 15, 1);
        wait_idle();
        chk("down_loads", loads, 17);
        chk("down_duty", int'(duty_out), 0);

        cmd(3, 0, 0);
        wait_idle();
        chk("zero_fields_cycles", elapsed, 3);

        cmd(0, 15, 1);
        wait_idle();
        cmd(100, 1, 2);
        wait_duty(20);
        start     = 1'b0;
        cmd_valid = 1'b1;
        cmd_duty  = 8'd7;
        repeat (10) tick();
        start     = 1'b1;
        cmd_valid = 1'b0;
        wait_idle();
        chk("freeze_cycles", elapsed, 210);
        chk("freeze_duty", int'(duty_out), 100);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmd(0, 3, 5);
        chk("equal_done", int'(done), 1);
        chk("equal_busy", int'(busy), 0);
        cmd_duty  = 8'd5;
        cmd_step  = 4'd1;
        cmd_rate  = 16'd1;
        cmd_valid = 1'b1;
        tick();
        cmd_duty = 8'd2;
        n = 0;
        while (n < 100 && !(m_busy != 0 && m_target == 2)) begin
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        chk("b2b_gap", n, 6);
        wait_idle();
        chk("b2b_duty", int'(duty_out), 2);

        cmd(100, 1, 1);
        wait_duty(60);
        rst = 1'b1;
        tick();
        chk("rst_duty", int'(duty_out), 0);
        chk("rst_ready", int'(cmd_ready), 0);
        rst = 1'b0;
        tick();
        chk("rst_release_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 9) != 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_duty  = ($urandom_range(0, 7) == 0) ? 8'(m_duty) : 8'($urandom_range(0, 255));
            cmd_step  = 4'($urandom_range(0, 15));
            cmd_rate  = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 3));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
